inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader_if.sv | 28 ++
 rtl/inst_mem_loader.sv | 120 ++++++++++++
 tb/tb_inst_mem_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
// The loader itself sits on the slave side; the byte source and memory sit on the master side.
interface inst_mem_loader_if #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32
);
    logic                        i_load_start;
    logic                        i_rx_valid;
    logic [7:0]                  i_rx_data;
    logic                        o_write_inst_mem;
    logic [PC_BITS-1:0]          o_inst_mem_addr;
    logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
    logic                        o_busy;
    logic                        o_load_done;
    logic                        o_overflow;

    modport master (
        output i_load_start, i_rx_valid, i_rx_data,
        input  o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
        input  o_busy, o_load_done, o_overflow
    );

    modport slave (
        input  i_load_start, i_rx_valid, i_rx_data,
        output o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
        output o_busy, o_load_done, o_overflow
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Assembles received bytes MSB-first into 32-bit words and writes them to
// consecutive instruction-memory addresses until an all-ones HLT word arrives.
//
// state | meaning
// IDLE  | out of reset, waiting for a load request
// RECV  | collecting bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | HLT written, load finished
// ERROR | memory full before HLT
module inst_mem_loader #(
    parameter int PC_BITS          = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int INST_ADDRS_BITS  = 11
) (
    input logic              clk,
    input logic              rst,
    inst_mem_loader_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    localparam logic [INSTRUCTION_BITS-1:0] HLT = '1;

    logic [2:0]                  state_q, state_d;
    logic [INST_ADDRS_BITS-1:0]  addr_q, addr_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [INSTRUCTION_BITS-1:0] word_q, word_d;
    logic                        write_q, write_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        ovf_q, ovf_d;
    logic [INSTRUCTION_BITS-1:0] word_shift;
    logic [PC_BITS-1:0]          addr_ext;

    assign word_shift = {word_q[INSTRUCTION_BITS-9:0], bus.i_rx_data};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        if (bus.i_load_start) begin
            // A restart drops any byte presented in the same cycle.
            state_d = RECV;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RECV: begin
                    if (bus.i_rx_valid) begin
                        word_d = word_shift;
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (word_q == HLT) begin
                        state_d = DONE;
                    end else if (&addr_q) begin
                        state_d = ERROR;
                    end else begin
                        // A byte arriving during the strobe already belongs to the next word.
                        state_d = RECV;
                        addr_d  = addr_q + INST_ADDRS_BITS'(1);
                        cnt_d   = '0;
                        if (bus.i_rx_valid) begin
                            word_d = word_shift;
                            cnt_d  = 2'd1;
                        end
                    end
                end
                IDLE, DONE, ERROR: ;
                default: state_d = IDLE;
            endcase
        end
        write_d = (state_d == WRITE);
        busy_d  = (state_d == RECV) || (state_d == WRITE);
        done_d  = (state_d == DONE);
        ovf_d   = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        addr_ext                      = '0;
        addr_ext[INST_ADDRS_BITS-1:0] = addr_q;
    end

    assign bus.o_write_inst_mem = write_q;
    assign bus.o_inst_mem_addr  = addr_ext;
    assign bus.o_inst_mem_data  = word_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_load_done      = done_q;
    assign bus.o_overflow       = ovf_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Drives a full-depth loader and a 4-word loader with the same byte stream and
// compares both against a per-instance behavioural model every cycle.
module tb_inst_mem_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       rx_valid;
    logic [7:0] rx_data;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    inst_mem_loader_if #(.PC_BITS(32), .INSTRUCTION_BITS(32)) bus_a ();
    inst_mem_loader_if #(.PC_BITS(32), .INSTRUCTION_BITS(32)) bus_b ();

    assign bus_a.i_load_start = load_start;
    assign bus_a.i_rx_valid   = rx_valid;
    assign bus_a.i_rx_data    = rx_data;
    assign bus_b.i_load_start = load_start;
    assign bus_b.i_rx_valid   = rx_valid;
    assign bus_b.i_rx_data    = rx_data;

    inst_mem_loader #(.PC_BITS(32), .INSTRUCTION_BITS(32), .INST_ADDRS_BITS(11)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    inst_mem_loader #(.PC_BITS(32), .INSTRUCTION_BITS(32), .INST_ADDRS_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // Model: "loading" flag, bytes collected so far, address, word, pending write.
    int unsigned depth [2] = '{2048, 4};
    bit          m_act [2];
    bit          m_done [2];
    bit          m_ovf [2];
    bit          m_wr [2];
    int          m_nb [2];
    int unsigned m_addr [2];
    logic [31:0] m_word [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input int k, input bit r, input bit s, input bit v, input logic [7:0] d);
        if (!r) begin
            m_act[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_wr[k] = 0;
            m_nb[k] = 0; m_addr[k] = 0; m_word[k] = '0;
        end else if (s) begin
            m_act[k] = 1; m_done[k] = 0; m_ovf[k] = 0; m_wr[k] = 0;
            m_nb[k] = 0; m_addr[k] = 0;
        end else if (m_wr[k]) begin
            m_wr[k] = 0;
            if (m_word[k] == 32'hFFFF_FFFF) begin
                m_act[k] = 0; m_done[k] = 1;
            end else if (m_addr[k] == depth[k] - 1) begin
                m_act[k] = 0; m_ovf[k] = 1;
            end else begin
                m_addr[k]++;
                m_nb[k] = 0;
                if (v) begin
                    m_word[k] = {m_word[k][23:0], d};
                    m_nb[k] = 1;
                end
            end
        end else if (m_act[k] && v) begin
            m_word[k] = {m_word[k][23:0], d};
            m_nb[k]++;
            if (m_nb[k] == 4) begin
                m_nb[k] = 0;
                m_wr[k] = 1;
            end
        end
    endtask

    task automatic compare(input string who, input int k, input logic wr, input logic [31:0] a,
                           input logic [31:0] dt, input logic b, input logic dn, input logic ov);
        check({who, ".write"}, 32'(wr), 32'(m_wr[k]));
        check({who, ".addr"}, a, m_addr[k]);
        check({who, ".data"}, dt, m_word[k]);
        check({who, ".busy"}, 32'(b), 32'(m_act[k]));
        check({who, ".done"}, 32'(dn), 32'(m_done[k]));
        check({who, ".ovf"}, 32'(ov), 32'(m_ovf[k]));
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
        rst = r; load_start = s; rx_valid = v; rx_data = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model(k, r, s, v, d);
        #1;
        compare("a", 0, bus_a.o_write_inst_mem, bus_a.o_inst_mem_addr, bus_a.o_inst_mem_data,
                bus_a.o_busy, bus_a.o_load_done, bus_a.o_overflow);
        compare("b", 1, bus_b.o_write_inst_mem, bus_b.o_inst_mem_addr, bus_b.o_inst_mem_data,
                bus_b.o_busy, bus_b.o_load_done, bus_b.o_overflow);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic start();
        step(1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    initial begin
        rst = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        check("rst.write", 32'(bus_a.o_write_inst_mem), 0);
        check("rst.addr", bus_a.o_inst_mem_addr, 0);
        check("rst.data", bus_a.o_inst_mem_data, 0);
        check("rst.busy", 32'(bus_a.o_busy), 0);

        // Two-word program ending in HLT.
        start();
        check("p1.busy", 32'(bus_a.o_busy), 1);
        send_word(32'h2001_0005);
        check("p1.w0.write", 32'(bus_a.o_write_inst_mem), 1);
        check("p1.w0.addr", bus_a.o_inst_mem_addr, 0);
        check("p1.w0.data", bus_a.o_inst_mem_data, 32'h2001_0005);
        idle();
        check("p1.w0.once", 32'(bus_a.o_write_inst_mem), 0);
        send_word(32'hFFFF_FFFF);
        check("p1.hlt.addr", bus_a.o_inst_mem_addr, 1);
        check("p1.hlt.data", bus_a.o_inst_mem_data, 32'hFFFF_FFFF);
        idle();
        check("p1.done", 32'(bus_a.o_load_done), 1);
        check("p1.idle", 32'(bus_a.o_busy), 0);
        send_word(32'h1234_5678);
        check("p1.ignore", 32'(bus_a.o_write_inst_mem), 0);

        // First byte of the next word lands in the write cycle.
        start();
        send_word(32'h1122_3344);
        send(8'hAA);
        check("b2b.gap", 32'(bus_a.o_write_inst_mem), 0);
        send(8'hBB); send(8'hCC); send(8'hDD);
        check("b2b.write", 32'(bus_a.o_write_inst_mem), 1);
        check("b2b.addr", bus_a.o_inst_mem_addr, 1);
        check("b2b.data", bus_a.o_inst_mem_data, 32'hAABB_CCDD);

        // Start with a byte in the same cycle: byte dropped.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h55);
        send(8'h01); send(8'h02); send(8'h03);
        check("drop.nowr", 32'(bus_a.o_write_inst_mem), 0);
        send(8'h04);
        check("drop.data", bus_a.o_inst_mem_data, 32'h0102_0304);
        check("drop.addr", bus_a.o_inst_mem_addr, 0);

        // Restart mid-word discards the partial word.
        start();
        send(8'hEE); send(8'hEF);
        start();
        send_word(32'hC0DE_0001);
        check("rs.write", 32'(bus_a.o_write_inst_mem), 1);
        check("rs.addr", bus_a.o_inst_mem_addr, 0);
        check("rs.data", bus_a.o_inst_mem_data, 32'hC0DE_0001);

        // Reset after three bytes, then bytes without a start.
        start();
        send(8'h10); send(8'h20); send(8'h30);
        step(1'b0, 1'b0, 1'b1, 8'h40);
        check("mid.busy", 32'(bus_a.o_busy), 0);
        check("mid.data", bus_a.o_inst_mem_data, 0);
        for (int i = 0; i < 8; i++) begin
            send(8'(i));
            check("mid.nowr", 32'(bus_a.o_write_inst_mem), 0);
        end

        // Small memory fills up without HLT.
        start();
        for (int w = 0; w < 4; w++) begin
            send_word(32'hA000_0000 + 32'(w));
            check("ovf.write", 32'(bus_b.o_write_inst_mem), 1);
            check("ovf.addr", bus_b.o_inst_mem_addr, 32'(w));
        end
        idle();
        check("ovf.flag", 32'(bus_b.o_overflow), 1);
        check("ovf.busy", 32'(bus_b.o_busy), 0);
        for (int i = 0; i < 8; i++) begin
            send(8'h77);
            check("ovf.nowr", 32'(bus_b.o_write_inst_mem), 0);
        end

        // Random traffic, biased toward 0xFF bytes so HLT words appear.
        start();
        for (int i = 0; i < 4000; i++) begin
            bit r, s, v;
            logic [7:0] d;
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 9) < 4) ? 8'hFF : 8'($urandom);
            step(r, s, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
